xin_conditioner: RTL

- Upstream input stage for the two-input sequence FSM.
- Takes two raw, asynchronous, bouncing push-button levels (btn1, btn0).
- Synchronises and debounces each one, then encodes every accepted press as a single-cycle pulse on x1 or x0.
- Guarantees x1 and x0 are never high in the same cycle, which is what the downstream FSM requires from its x inputs.

---
 rtl/xin_pkg.sv | 14 +
 rtl/xin_debounce.sv | 91 +++++++++
 rtl/xin_conditioner.sv | 79 +++++++
 3 files changed

// File: rtl/xin_pkg.sv
// Shared types and constants for the xin_conditioner button input stage.
package xin_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } xin_db_state_t;

    localparam int         XIN_SYNC_STAGES = 2;
    localparam logic [7:0] XIN_CNT_MAX     = 8'd255;

endpackage

// File: rtl/xin_debounce.sv
// One button channel: two-flop synchroniser feeding a debounce FSM that
// emits a registered single-cycle press_evt for every accepted press.
module xin_debounce
    import xin_pkg::*;
#(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press_evt,
    output logic active
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [XIN_SYNC_STAGES-1:0] sync_q;
    logic                       sync;
    xin_db_state_t              state;
    logic [CNT_W-1:0]           cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[XIN_SYNC_STAGES-2:0], btn};
        end
    end

    assign sync = sync_q[XIN_SYNC_STAGES-1];

    // cnt == CNT_LAST means this edge is the DB_CYCLES-th stable sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            press_evt <= 1'b0;
            active    <= 1'b0;
        end else begin
            press_evt <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync) begin
                        state  <= PRESS_WAIT;
                        cnt    <= CNT_ONE;
                        active <= 1'b1;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        active <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= HELD;
                        cnt       <= '0;
                        press_evt <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!sync) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        active <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/xin_conditioner.sv
// Two debounced buttons encoded into mutually exclusive x1/x0 pulses.
// Optional saturating press counters are built when XIN_PRESS_CNT_EN is defined.
module xin_conditioner
    import xin_pkg::*;
#(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn1,
    input  logic       btn0,
    output logic       x1,
    output logic       x0,
    output logic       busy
`ifdef XIN_PRESS_CNT_EN
    ,
    output logic [7:0] cnt1,
    output logic [7:0] cnt0
`endif
);

    logic evt1, evt0;
    logic act1, act0;
    logic pending;
    logic x1_next, x0_next;

    xin_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db1 (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn1),
        .press_evt (evt1),
        .active    (act1)
    );

    xin_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db0 (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn0),
        .press_evt (evt0),
        .active    (act0)
    );

    // On a collision x1 wins; x0 is parked in pending and sent next cycle.
    assign x1_next = evt1;
    assign x0_next = (evt0 && !evt1) || pending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x1      <= 1'b0;
            x0      <= 1'b0;
            pending <= 1'b0;
        end else begin
            x1      <= x1_next;
            x0      <= x0_next;
            pending <= evt0 && evt1;
        end
    end

    assign busy = act1 || act0 || pending;

`ifdef XIN_PRESS_CNT_EN
    // Counters step on the same edge that raises the matching x pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt1 <= '0;
            cnt0 <= '0;
        end else begin
            if (x1_next && cnt1 != XIN_CNT_MAX) begin
                cnt1 <= cnt1 + 8'd1;
            end
            if (x0_next && cnt0 != XIN_CNT_MAX) begin
                cnt0 <= cnt0 + 8'd1;
            end
        end
    end
`endif

endmodule
